// File: rtl/mul_iter_64.sv
// rtl/mul_iter_64.sv - iterative radix-2 shift-add multiplier (MUL / UMULH)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   synchronous active-low reset
//   start    in   request a multiply, accepted when busy=0
//   op       in   0 = low half of product, 1 = high half (unsigned)
//   a        in   multiplicand
//   b        in   multiplier
//   busy     out  high while iterating
//   done     out  one-cycle pulse when result becomes valid
//   result   out  selected product half, held until the next completion

module mul_iter_64 #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               op_q, op_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // One shift-add step; the sum keeps one extra bit so the adder carry
    // shifts into the top of the product instead of being dropped.
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_step;

    always_comb begin
        sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_step = {sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        op_d     = op_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a new start just like IDLE for back-to-back use.
                if (start) begin
                    state_d = S_RUN;
                    mcand_d = a;
                    op_d    = op;
                    prod_d  = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Result is taken from the final step's product so it is
                    // valid in the same cycle done is raised.
                    state_d  = S_DONE;
                    result_d = op_q ? prod_step[2*WIDTH-1:WIDTH]
                                    : prod_step[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            op_q     <= 1'b0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            op_q     <= op_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mul_iter_64.sv
// tb/tb_mul_iter_64.sv - self-checking bench for mul_iter_64

module tb_mul_iter_64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int vectors = 0;
    int miscompares = 0;

    mul_iter_64 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    // Reference: full 128-bit unsigned product, then select the half.
    function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                            input logic sel);
        logic [127:0] p;
        p = {64'd0, x} * {64'd0, y};
        return sel ? p[127:64] : p[63:0];
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Drives a one-cycle start, then waits (bounded) for done. Returns the
    // number of negedges from the start edge to the done cycle.
    task automatic do_mul(input logic [63:0] ta, input logic [63:0] tbv, input logic top,
                          output logic [63:0] res, output int cyc);
        a = ta; b = tbv; op = top; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        res = result;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; op = 1'b1; a = 64'd9; b = 64'd9;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b result=%h, need 0 0 0", busy, done, result);
        end
        reset_n = 1'b1; start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b need 0", busy);
        end
    endtask

    task automatic test_basic();
        int busy_cnt;
        a = 64'd3; b = 64'd5; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        for (int i = 1; i <= 64; i++) begin
            if (busy === 1'b1 && done === 1'b0) busy_cnt++;
            @(negedge clk);
        end
        vectors++;
        if (busy_cnt != 64) begin
            miscompares++;
            $display("FAIL basic_busy: busy cycles=%0d need 64", busy_cnt);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== 64'd15) begin
            miscompares++;
            $display("FAIL basic_done: done=%b busy=%b result=%h, need 1 0 f", done, busy, result);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || result !== 64'd15) begin
            miscompares++;
            $display("FAIL basic_pulse: done=%b result=%h, need 0 f", done, result);
        end
    endtask

    task automatic test_corners();
        logic [63:0] ta [4];
        logic [63:0] tbv [4];
        logic        top [4];
        logic [63:0] exp_v [4];
        logic [63:0] res;
        int cyc;
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tbv[0] = 64'd2; top[0] = 1'b1; exp_v[0] = 64'd1;
        ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tbv[1] = 64'd2; top[1] = 1'b0; exp_v[1] = 64'hFFFF_FFFF_FFFF_FFFE;
        ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tbv[2] = 64'hFFFF_FFFF_FFFF_FFFF; top[2] = 1'b1;
        exp_v[2] = 64'hFFFF_FFFF_FFFF_FFFE;
        ta[3] = 64'hFFFF_FFFF_FFFF_FFFF; tbv[3] = 64'hFFFF_FFFF_FFFF_FFFF; top[3] = 1'b0; exp_v[3] = 64'd1;
        for (int i = 0; i < 4; i++) begin
            do_mul(ta[i], tbv[i], top[i], res, cyc);
            vectors++;
            if (cyc != 65 || res !== exp_v[i]) begin
                miscompares++;
                $display("FAIL corner%0d: cycles=%0d result=%h, need 65 %h", i, cyc, res, exp_v[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_run_disturb();
        logic [63:0] a0, b0, exp_r;
        logic        op0;
        int bad, extra;
        a0 = rnd64(); b0 = rnd64(); op0 = 1'($urandom_range(0, 1));
        exp_r = ref_mul(a0, b0, op0);
        a = a0; b = b0; op = op0; start = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int i = 1; i <= 64; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            start = 1'($urandom_range(0, 1));
            a = rnd64(); b = rnd64(); op = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL disturb_busy: bad cycles=%0d need 0", bad);
        end
        vectors++;
        if (done !== 1'b1 || result !== exp_r) begin
            miscompares++;
            $display("FAIL disturb_result: done=%b result=%h, need 1 %h", done, result, exp_r);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done !== 1'b0) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL disturb_single_done: extra dones=%0d need 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] first;
        int bad;
        first = ref_mul(64'h1234_5678, 64'h10, 1'b0);
        a = 64'h1234_5678; b = 64'h10; op = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int i = 1; i < 64; i++) @(negedge clk);
        a = 64'd7; b = 64'd6; op = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || result !== first) begin
            miscompares++;
            $display("FAIL b2b_first: done=%b result=%h, need 1 %h", done, result, first);
        end
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || result !== first) bad++;
            @(negedge clk);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL b2b_hold: bad cycles=%0d need 0", bad);
        end
        vectors++;
        if (done !== 1'b1 || result !== 64'd42) begin
            miscompares++;
            $display("FAIL b2b_second: done=%b result=%h, need 1 2a", done, result);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [63:0] res;
        int cyc, extra;
        a = rnd64() | 64'd1; b = rnd64() | 64'd1; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 31; i++) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
            miscompares++;
            $display("FAIL midreset: busy=%b done=%b result=%h, need 0 0 0", busy, done, result);
        end
        extra = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: active cycles=%0d need 0", extra);
        end
        do_mul(64'd0, 64'd12345, 1'b0, res, cyc);
        vectors++;
        if (cyc != 65 || res !== 64'd0) begin
            miscompares++;
            $display("FAIL midreset_fresh: cycles=%0d result=%h, need 65 0", cyc, res);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [63:0] ta, tbv, res, exp_r;
        logic        top;
        int cyc;
        for (int i = 0; i < 24; i++) begin
            ta = rnd64(); tbv = rnd64(); top = 1'($urandom_range(0, 1));
            if (i % 6 == 5) ta = 64'hFFFF_FFFF_FFFF_FFFF;
            exp_r = ref_mul(ta, tbv, top);
            do_mul(ta, tbv, top, res, cyc);
            vectors++;
            if (cyc != 65 || res !== exp_r) begin
                miscompares++;
                $display("FAIL random%0d: a=%h b=%h op=%b cycles=%0d result=%h, need 65 %h",
                         i, ta, tbv, top, cyc, res, exp_r);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_corners();
        test_run_disturb();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_iter_64.md
Name: mul_iter_64

Overview:
- Iterative radix-2 shift-add multiplier in the execute stage.
- Consumes the 64-bit ALU-B operand produced by the register/immediate 2:1 operand-select mux, plus operand A from the register file.
- Provides LEGv8 MUL (low 64 bits of the product) and UMULH (high 64 bits, unsigned).
- Multi-cycle, with a start/busy/done handshake toward the pipeline stall logic.

Parameters:
- WIDTH, 64, operand and result width in bits; the full product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request a multiply; accepted only when busy=0.
- op  input  1  0 = MUL (low half), 1 = UMULH (high half); captured on acceptance.
- a  input  WIDTH  multiplicand (register file read port 1).
- b  input  WIDTH  multiplier (output of the operand-select mux).
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  WIDTH  selected half of the product; stable from done until the next accepted start.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, result=0.
  - Internal product register = 0, counter = 0.
  - Applies mid-operation: any multiply in progress is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN.
  - On that edge: capture mcand=a and op.
  - Load prod[2W-1:W]=0 and prod[W-1:0]=b; cnt=0.
- RUN (busy=1, done=0):
  - Each edge computes sum = prod[2W-1:W] + (prod[0] ? mcand : 0), kept WIDTH+1 bits wide.
  - Then prod = {sum, prod[W-1:1]}, a right shift of 2W+1 bits truncated to 2W; the adder carry must not be lost.
  - cnt increments by 1.
  - When cnt==WIDTH-1 on an edge, perform the final step and go to DONE.
  - start is ignored in RUN; a, b and op may change freely without effect.
- DONE (busy=0, done=1 for exactly one cycle):
  - result = op ? prod[2W-1:W] : prod[W-1:0], registered.
  - Next state is IDLE.
  - If start=1 in DONE, accept it exactly as from IDLE and go directly to RUN (back-to-back throughput).
- Latency:
  - start sampled at edge E0.
  - busy=1 for WIDTH cycles (after E0 through E_WIDTH).
  - done=1 in the cycle after edge E_WIDTH, i.e. WIDTH+1 cycles after E0.
  - Latency is fixed, independent of operand values (no early termination).
- result:
  - Holds its last value in IDLE and RUN; it changes only on entry to DONE or on reset.
- Arithmetic:
  - Unsigned throughout; MUL low half is identical for signed operands.
  - Product of (2^W-1)*(2^W-1) must be exact.
- start with reset_n=0 on the same edge: reset wins.

Test Plan:
- Reset, a=3, b=5, op=0, start pulse → busy high for 64 cycles, done pulse on the 65th cycle after the start edge, result=15.
- a=0xFFFF_FFFF_FFFF_FFFF, b=2, op=1 → result=1. Repeat with op=0 → result=0xFFFF_FFFF_FFFF_FFFE.
- a=b=0xFFFF_FFFF_FFFF_FFFF, op=1 → result=0xFFFF_FFFF_FFFF_FFFE (carry path). With op=0 → result=1.
- During RUN, toggle start and change a/b/op each cycle → exactly one done; result matches the originally captured operands; busy never drops early.
- start held high through DONE with new a=7, b=6 → second RUN begins with no IDLE cycle; second done shows 42; first result remains held until the second done.
- reset_n=0 for one cycle at cnt=30 mid-RUN → busy=0, done=0, result=0 next cycle; no done pulse follows. A fresh start (a=0, b=12345) yields result=0 after 65 cycles.
